// File: rtl/branch_cond_unit_if.sv
// Bus bundle between the decode/ALU side and the branch condition unit.
// Clock and reset stay plain module ports; everything else travels here.
//
// Handshake: BR_VALID is a valid-only strobe with no ready return. A branch
// presented while FLUSH=1 or STALL=1 is not evaluated and is not retained.
// The producer is expected to kill or replay it. FLUSH is the only
// back-pressure this unit gives.
interface branch_cond_unit_if #(
    parameter int FLAGS_LENGTH = 5,
    parameter int PC_WIDTH     = 10,
    parameter int CNT_WIDTH    = 12
);
    // Inputs to the unit
    logic                    STALL;
    logic                    FLAGS_WE;
    logic [FLAGS_LENGTH-1:0] ALU_FLAGS;
    logic                    BR_VALID;
    logic [2:0]              BR_MODE;
    logic [FLAGS_LENGTH-1:0] IM_FLAGS;
    logic [PC_WIDTH-1:0]     BR_TARGET;
    logic                    LOOP_LOAD;
    logic [CNT_WIDTH-1:0]    LOOP_COUNT;

    // Outputs from the unit
    logic                    BRANCH_SEL;
    logic [PC_WIDTH-1:0]     BRANCH_PC;
    logic                    FLUSH;
    logic [FLAGS_LENGTH-1:0] FLAGS_Q;
    logic                    LOOP_ACTIVE;

    // Decode/ALU side: drives requests, observes the decision
    modport master (
        output STALL, FLAGS_WE, ALU_FLAGS, BR_VALID, BR_MODE, IM_FLAGS,
               BR_TARGET, LOOP_LOAD, LOOP_COUNT,
        input  BRANCH_SEL, BRANCH_PC, FLUSH, FLAGS_Q, LOOP_ACTIVE
    );

    // Branch condition unit side
    modport slave (
        input  STALL, FLAGS_WE, ALU_FLAGS, BR_VALID, BR_MODE, IM_FLAGS,
               BR_TARGET, LOOP_LOAD, LOOP_COUNT,
        output BRANCH_SEL, BRANCH_PC, FLUSH, FLAGS_Q, LOOP_ACTIVE
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: registered flag file with same-cycle forwarding,
// eight-mode condition check against an immediate mask, a zero-overhead
// hardware loop counter, and a programmable flush window after taken branches.
// All outputs come straight from registers.
module branch_cond_unit #(
    parameter int FLAGS_LENGTH = 5,
    parameter int PC_WIDTH     = 10,
    parameter int CNT_WIDTH    = 12,
    parameter int FLUSH_CYCLES = 2     // legal 0..7, 0 disables flush
) (
    input  logic                CLK,
    input  logic                RST_N,
    branch_cond_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        MODE_NEVER   = 3'd0,
        MODE_ALWAYS  = 3'd1,
        MODE_ANY     = 3'd2,
        MODE_ALL     = 3'd3,
        MODE_NONE    = 3'd4,
        MODE_NOT_ALL = 3'd5,
        MODE_LOOP    = 3'd6,
        MODE_RSVD    = 3'd7
    } br_mode_e;

    // The flush counter is 3 bits wide, which covers the whole legal range.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    // State registers and their next-state values
    logic [FLAGS_LENGTH-1:0] flags_q,      flags_d;
    logic [CNT_WIDTH-1:0]    loop_cnt_q,   loop_cnt_d;
    logic [2:0]              flush_cnt_q,  flush_cnt_d;
    logic                    branch_sel_q, branch_sel_d;
    logic [PC_WIDTH-1:0]     branch_pc_q,  branch_pc_d;

    // Decode helpers
    logic                    flush_active;
    logic                    flags_we_eff;
    logic                    eval_en;
    logic [FLAGS_LENGTH-1:0] eff_flags;
    logic [FLAGS_LENGTH-1:0] masked;
    logic                    any_hit;
    logic                    all_hit;
    logic                    loop_nz;
    logic                    cond_true;
    logic                    taken;
    logic                    loop_taken;
    br_mode_e                mode;

    // While the flush window is open, flag writes and branches are shadow
    // instructions and are dropped. Stall gating is applied at the registers.
    always_comb begin
        flush_active = (flush_cnt_q != 3'd0);
        flags_we_eff = bus.FLAGS_WE & ~flush_active;
        eval_en      = bus.BR_VALID & ~flush_active;
        mode         = br_mode_e'(bus.BR_MODE);
    end

    // Effective flags forward a same-cycle ALU write ahead of the register.
    always_comb begin
        eff_flags = flags_we_eff ? bus.ALU_FLAGS : flags_q;
        masked    = eff_flags & bus.IM_FLAGS;
        any_hit   = (masked != '0);
        // An all-zero mask makes ALL trivially true and NOT_ALL false.
        all_hit   = (masked == bus.IM_FLAGS);
        loop_nz   = (loop_cnt_q != '0);
    end

    // Condition evaluation for the selected mode
    always_comb begin
        cond_true = 1'b0;
        case (mode)
            MODE_NEVER:   cond_true = 1'b0;
            MODE_ALWAYS:  cond_true = 1'b1;
            MODE_ANY:     cond_true = any_hit;
            MODE_ALL:     cond_true = all_hit;
            MODE_NONE:    cond_true = ~any_hit;
            MODE_NOT_ALL: cond_true = ~all_hit;
            MODE_LOOP:    cond_true = loop_nz;
            MODE_RSVD:    cond_true = 1'b0;
            default:      cond_true = 1'b0;
        endcase
        taken      = eval_en & cond_true;
        loop_taken = taken & (mode == MODE_LOOP);
    end

    // Next-state values; STALL is applied where the registers update
    always_comb begin
        flags_d = flags_we_eff ? bus.ALU_FLAGS : flags_q;

        // A load beats a same-cycle decrement. The evaluation above still
        // uses the old count to decide taken/not taken.
        if (bus.LOOP_LOAD) begin
            loop_cnt_d = bus.LOOP_COUNT;
        end else if (loop_taken) begin
            loop_cnt_d = loop_cnt_q - CNT_WIDTH'(1);
        end else begin
            loop_cnt_d = loop_cnt_q;
        end

        // A taken branch opens the window. Otherwise the window counts down to zero.
        if (taken) begin
            flush_cnt_d = FLUSH_INIT;
        end else if (flush_active) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end

        branch_sel_d = taken;
        branch_pc_d  = taken ? bus.BR_TARGET : branch_pc_q;
    end

    // State update: async clear, STALL freezes everything
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q      <= '0;
            loop_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            branch_sel_q <= 1'b0;
            branch_pc_q  <= '0;
        end else if (!bus.STALL) begin
            flags_q      <= flags_d;
            loop_cnt_q   <= loop_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            branch_sel_q <= branch_sel_d;
            branch_pc_q  <= branch_pc_d;
        end
    end

    // Output views of the registered state
    always_comb begin
        bus.BRANCH_SEL  = branch_sel_q;
        bus.BRANCH_PC   = branch_pc_q;
        bus.FLUSH       = (flush_cnt_q != 3'd0);
        bus.FLAGS_Q     = flags_q;
        bus.LOOP_ACTIVE = (loop_cnt_q != '0);
    end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Parametrised successor to the IPPro datapath branch check.
- Holds a registered flag file with same-cycle forwarding. Evaluates one of eight condition modes against an immediate flag mask.
- Runs a hardware loop counter for zero-overhead loops.
- Issues a registered branch decision, target PC and a programmable flush window for shadow instructions.
- Sits between the ALU flag outputs and the PC/fetch stage.

Parameters:
- FLAGS_LENGTH, 5, width of ALU and immediate flag vectors.
- PC_WIDTH, 10, width of branch target / program counter.
- CNT_WIDTH, 12, width of hardware loop counter.
- FLUSH_CYCLES, 2, cycles FLUSH is held after a taken branch. Legal range 0..7; 0 disables flush.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- STALL  in  1  global pipeline stall; freezes all state.
- FLAGS_WE  in  1  capture ALU_FLAGS into flag register.
- ALU_FLAGS  in  FLAGS_LENGTH  flags from ALU.
- BR_VALID  in  1  branch instruction present this cycle.
- BR_MODE  in  3  condition mode.
- IM_FLAGS  in  FLAGS_LENGTH  immediate flag mask from instruction.
- BR_TARGET  in  PC_WIDTH  branch target address.
- LOOP_LOAD  in  1  load loop counter.
- LOOP_COUNT  in  CNT_WIDTH  loop iteration count.
- BRANCH_SEL  out  1  registered branch-taken pulse.
- BRANCH_PC  out  PC_WIDTH  registered target of last taken branch.
- FLUSH  out  1  kill shadow instructions.
- FLAGS_Q  out  FLAGS_LENGTH  current flag register.
- LOOP_ACTIVE  out  1  loop counter non-zero.

Behaviour:
- Reset is asynchronous on RST_N low. All outputs, the flag register, the loop counter and the flush counter clear to 0.
- STALL=1 holds every register, including BRANCH_SEL, FLUSH and the counters. No load, decrement or evaluation occurs.
- Flag register: FLAGS_Q <= ALU_FLAGS when FLAGS_WE=1, STALL=0 and FLUSH=0.
- Effective flags: EF = ALU_FLAGS when FLAGS_WE=1 in the same cycle (forwarding), otherwise FLAGS_Q. Let M = EF & IM_FLAGS.
- Modes:
  - 0 NEVER: not taken.
  - 1 ALWAYS: taken.
  - 2 ANY: taken when M != 0.
  - 3 ALL: taken when M == IM_FLAGS.
  - 4 NONE: taken when M == 0.
  - 5 NOT_ALL: taken when M != IM_FLAGS.
  - 6 LOOP: taken when the loop counter != 0.
  - 7 reserved: behaves as NEVER.
- IM_FLAGS=0 corner cases: ALL is taken, NOT_ALL is not taken.
- Evaluation happens only when BR_VALID=1, STALL=0 and FLUSH=0.
- Latency is one cycle. A taken evaluation in cycle N gives BRANCH_SEL=1 and BRANCH_PC=BR_TARGET in cycle N+1.
- BRANCH_SEL is high for exactly one unstalled cycle per taken branch. BRANCH_PC holds its value until the next taken branch.
- Loop counter:
  - LOOP_LOAD=1 loads LOOP_COUNT.
  - A LOOP-mode evaluation with counter != 0 decrements by 1 and is taken.
  - At counter 0 it is not taken and the counter stays 0; there is no wrap.
  - LOOP_LOAD and a LOOP evaluation in the same cycle: the evaluation uses the old value, the load wins and the decrement is discarded.
  - LOOP_LOAD is honoured during FLUSH.
  - LOOP_ACTIVE = (counter != 0), registered view.
- Flush:
  - A taken branch loads the flush counter with FLUSH_CYCLES.
  - FLUSH = (flush counter != 0). It asserts in the same cycle as BRANCH_SEL and stays high for FLUSH_CYCLES unstalled cycles.
  - While FLUSH=1, BR_VALID and FLAGS_WE are ignored.
  - With FLUSH_CYCLES=0, FLUSH never asserts and back-to-back taken branches are legal.
- Reset mid-flush or mid-loop clears everything immediately; there is no resumption.

Test Plan:
- Reset: drive random inputs with RST_N=0 -> every output 0. Release RST_N -> all outputs still 0 until the first branch.
- Forwarding, FLAGS_LENGTH=5: FLAGS_Q=5'b00000; in the same cycle drive FLAGS_WE=1, ALU_FLAGS=5'b00100, BR_VALID=1, mode ANY, IM_FLAGS=5'b00110 -> next cycle BRANCH_SEL=1, BRANCH_PC=BR_TARGET, FLAGS_Q=5'b00100.
- Mode sweep: FLAGS_Q=5'b01010 -> ALL with IM=5'b01010 taken; ALL with IM=5'b01110 not taken; NONE with IM=5'b00101 taken; mode 7 not taken.
- Loop: LOOP_LOAD with LOOP_COUNT=3, then repeated LOOP branches (FLUSH_CYCLES=2) -> exactly 3 taken pulses, a 4th not taken. LOOP_ACTIVE falls after the 3rd.
- Flush shadow: a taken branch, then BR_VALID=1 with ALWAYS on the next 2 cycles -> FLUSH high for 2 cycles and both branches ignored. A branch in the 3rd cycle is taken.
- Stall: assert STALL while BRANCH_SEL=1 and FLUSH=1 for 4 cycles -> outputs frozen. After release, FLUSH continues its remaining count.
